// File: rtl/cam_gen_pkg.sv
// cam_gen_pkg: shared types and constants for the camera test-pattern transmitter.
//   - cam_state_t : frame timing FSM states
//   - MODE_*      : pattern select encodings (3 renders as solid)
//   - BAR_COLORS  : 8-entry RGB444 colour-bar table, left to right
//   - max2        : elaboration-time helper for counter sizing
package cam_gen_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_VBACK  = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_VFRONT = 3'd4
    } cam_state_t;

    localparam logic [1:0] MODE_BARS  = 2'd0;
    localparam logic [1:0] MODE_GRAD  = 2'd1;
    localparam logic [1:0] MODE_SOLID = 2'd2;

    localparam logic [11:0] BAR_COLORS [8] = '{
        12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
        12'hF0F, 12'hF00, 12'h00F, 12'h000
    };

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cam_px_gen_if.sv
// cam_px_gen_if: OV7670-style camera byte bus.
//   CAM_pclk    : pixel clock
//   CAM_href    : line valid; CAM_px_data carries a pixel byte only while it is 1
//   CAM_vsync   : frame sync, active high
//   CAM_px_data : 8-bit byte bus
// There is no back-pressure on this bus: the receiver samples CAM_px_data on
// every CAM_pclk rising edge where CAM_href is 1 (href acts as "valid", the
// receiver is always ready). The transmitter changes href/vsync/data only on
// pclk falling edges so they are stable at each rising edge.
// master = transmitter (camera model), slave = capture side.
interface cam_px_gen_if;
    logic       CAM_pclk;
    logic       CAM_href;
    logic       CAM_vsync;
    logic [7:0] CAM_px_data;

    modport master (
        output CAM_pclk,
        output CAM_href,
        output CAM_vsync,
        output CAM_px_data
    );

    modport slave (
        input CAM_pclk,
        input CAM_href,
        input CAM_vsync,
        input CAM_px_data
    );
endinterface

// File: rtl/cam_gen_pattern.sv
// cam_gen_pattern: combinational test-pattern colour for one pixel.
// Ports:
//   x, y      : pixel coordinate (x may exceed H_ACT-1 during blanking; the
//               caller masks those bytes)
//   mode      : MODE_BARS / MODE_GRAD / MODE_SOLID (3 = solid)
//   solid_rgb : colour used for solid modes
//   rgb       : RGB444 result {R, G, B}
module cam_gen_pattern
    import cam_gen_pkg::*;
#(
    parameter int H_ACT = 160,
    parameter int X_W   = 8,
    parameter int Y_W   = 7
) (
    input  logic [X_W-1:0] x,
    input  logic [Y_W-1:0] y,
    input  logic [1:0]     mode,
    input  logic [11:0]    solid_rgb,
    output logic [11:0]    rgb
);
    localparam int BAR_W = H_ACT / 8;

    logic [2:0] bar_idx;
    logic [3:0] x4;
    logic [3:0] y4;
    logic [3:0] sum4;

    always_comb begin
        // Bar index beyond 7 only happens in blanking, so truncation is harmless.
        bar_idx = 3'(x / X_W'(BAR_W));
        x4      = 4'(x);
        y4      = 4'(y);
        sum4    = x4 + y4;   // equals (x+y)[3:0]
        case (mode)
            MODE_BARS: rgb = BAR_COLORS[bar_idx];
            MODE_GRAD: rgb = {x4, y4, sum4};
            default:   rgb = solid_rgb;
        endcase
    end

endmodule

// File: rtl/cam_px_gen.sv
// cam_px_gen: synthesizable OV7670-style camera transmitter producing QQVGA
// RGB444 frames from an internal test pattern.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   enable     : start frames / keep streaming
//   mode       : pattern select (sampled at frame start)
//   solid_rgb  : solid colour (sampled at frame start)
//   cam        : camera byte bus (master modport)
//   frame_done : one-clk pulse at the end of each frame
//   state_dbg  : current timing FSM state
// Optional build macro CAM_GEN_SCROLL_EN: adds a frame counter f and renders
// the pattern at x' = (x + f) mod H_ACT so the image scrolls one pixel/frame.
module cam_px_gen
    import cam_gen_pkg::*;
#(
    parameter int H_ACT    = 160,
    parameter int V_ACT    = 120,
    parameter int H_BLANK  = 16,
    parameter int VS_LINES = 3,
    parameter int VB_LINES = 2,
    parameter int VF_LINES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         enable,
    input  logic [1:0]   mode,
    input  logic [11:0]  solid_rgb,
    cam_px_gen_if.master cam,
    output logic         frame_done,
    output cam_state_t   state_dbg
);
    localparam int LINE_TICKS = 2 * H_ACT + H_BLANK;
    localparam int VS_TICKS   = VS_LINES * LINE_TICKS;
    localparam int VB_TICKS   = VB_LINES * LINE_TICKS;
    localparam int VF_TICKS   = VF_LINES * LINE_TICKS;
    localparam int CNT_MAX    = max2(max2(LINE_TICKS, VS_TICKS), max2(VB_TICKS, VF_TICKS));
    localparam int CNT_W      = $clog2(CNT_MAX + 1);
    localparam int X_W        = $clog2(H_ACT);
    localparam int Y_W        = $clog2(V_ACT);

    localparam logic [CNT_W-1:0] LINE_LAST = CNT_W'(LINE_TICKS - 1);
    localparam logic [CNT_W-1:0] VS_LAST   = CNT_W'(VS_TICKS - 1);
    localparam logic [CNT_W-1:0] VB_LAST   = CNT_W'(VB_TICKS - 1);
    localparam logic [CNT_W-1:0] VF_LAST   = CNT_W'(VF_TICKS - 1);
    localparam logic [CNT_W-1:0] HREF_END  = CNT_W'(2 * H_ACT);
    localparam logic [Y_W-1:0]   Y_LAST    = Y_W'(V_ACT - 1);

    cam_state_t       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
    logic [Y_W-1:0]   y, y_n;
    logic             pclk, href, vsync;
    logic [7:0]       px_data, byte_n;
    logic             href_n, vsync_n, done_n, latch_n;
    logic [1:0]       mode_q;
    logic [11:0]      solid_q;
    logic             tick;
    logic [X_W-1:0]   px_x, pat_x;
    logic [11:0]      rgb;

    // pclk is 1 now, so this edge drives it low: the output update edge.
    assign tick = pclk;

    // Timing FSM state register; everything advances only on tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            y     <= '0;
        end else if (tick) begin
            state <= state_n;
            cnt   <= cnt_n;
            y     <= y_n;
        end
    end

    // Next state plus the values href/vsync/data take after this tick. In
    // ACTIVE, cnt is the byte position within the line (0 .. LINE_TICKS-1).
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        y_n     = y;
        href_n  = 1'b0;
        vsync_n = 1'b0;
        done_n  = 1'b0;
        latch_n = 1'b0;
        cnt_inc = cnt + 1'b1;
        case (state)
            ST_IDLE: begin
                if (enable) begin
                    state_n = ST_VSYNC;
                    cnt_n   = '0;
                    vsync_n = 1'b1;
                    latch_n = 1'b1;
                end
            end
            ST_VSYNC: begin
                if (cnt == VS_LAST) begin
                    state_n = ST_VBACK;
                    cnt_n   = '0;
                end else begin
                    cnt_n   = cnt_inc;
                    vsync_n = 1'b1;
                end
            end
            ST_VBACK: begin
                if (cnt == VB_LAST) begin
                    state_n = ST_ACTIVE;
                    cnt_n   = '0;
                    y_n     = '0;
                    href_n  = 1'b1;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            ST_ACTIVE: begin
                if (cnt == LINE_LAST) begin
                    cnt_n = '0;
                    if (y == Y_LAST) begin
                        state_n = ST_VFRONT;
                        y_n     = '0;
                    end else begin
                        y_n    = y + 1'b1;
                        href_n = 1'b1;
                    end
                end else begin
                    cnt_n  = cnt_inc;
                    href_n = (cnt_inc < HREF_END);
                end
            end
            ST_VFRONT: begin
                if (cnt == VF_LAST) begin
                    done_n = 1'b1;
                    cnt_n  = '0;
                    if (enable) begin
                        state_n = ST_VSYNC;
                        vsync_n = 1'b1;
                        latch_n = 1'b1;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
                y_n     = '0;
            end
        endcase
    end

    // x of the byte being presented next: byte index >> 1.
    assign px_x = cnt_n[X_W:1];

`ifdef CAM_GEN_SCROLL_EN
    logic [X_W-1:0] frame_cnt;
    logic [X_W:0]   x_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (tick && done_n) begin
            frame_cnt <= (frame_cnt == X_W'(H_ACT - 1)) ? '0 : frame_cnt + 1'b1;
        end
    end

    // Both operands are below H_ACT on active pixels, so one subtract wraps.
    always_comb begin
        x_sum = {1'b0, px_x} + {1'b0, frame_cnt};
        if (x_sum >= (X_W + 1)'(H_ACT)) begin
            x_sum = x_sum - (X_W + 1)'(H_ACT);
        end
        pat_x = x_sum[X_W-1:0];
    end
`else
    assign pat_x = px_x;
`endif

    cam_gen_pattern #(
        .H_ACT (H_ACT),
        .X_W   (X_W),
        .Y_W   (Y_W)
    ) u_pattern (
        .x         (pat_x),
        .y         (y_n),
        .mode      (mode_q),
        .solid_rgb (solid_q),
        .rgb       (rgb)
    );

    // Even byte {0, R}, odd byte {G, B}; bus held at 0 outside href.
    always_comb begin
        byte_n = 8'h00;
        if (href_n) begin
            byte_n = cnt_n[0] ? rgb[7:0] : {4'h0, rgb[11:8]};
        end
    end

    // pclk divider, registered outputs and frame-start pattern latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pclk       <= 1'b0;
            href       <= 1'b0;
            vsync      <= 1'b0;
            px_data    <= 8'h00;
            frame_done <= 1'b0;
            mode_q     <= MODE_BARS;
            solid_q    <= 12'h000;
        end else begin
            pclk       <= ~pclk;
            frame_done <= 1'b0;
            if (tick) begin
                href       <= href_n;
                vsync      <= vsync_n;
                px_data    <= byte_n;
                frame_done <= done_n;
                if (latch_n) begin
                    mode_q  <= mode;
                    solid_q <= solid_rgb;
                end
            end
        end
    end

    assign cam.CAM_pclk    = pclk;
    assign cam.CAM_href    = href;
    assign cam.CAM_vsync   = vsync;
    assign cam.CAM_px_data = px_data;
    assign state_dbg       = state;

endmodule

// File: tb/tb_cam_px_gen.sv
// tb_cam_px_gen: directed bench for cam_px_gen with a reduced geometry
// (32x8 active, 4 blank ticks) so several frames fit in a short run.
// Line = 68 ticks = 136 clk; frame = 15 lines = 2040 clk.
module tb_cam_px_gen;
    import cam_gen_pkg::*;

    localparam int TH  = 32;
    localparam int TV  = 8;
    localparam int TB  = 4;
    localparam int TVS = 3;
    localparam int TVB = 2;
    localparam int TVF = 2;
    localparam int L   = 2 * TH + TB;
    localparam int FRAME_CLK = (TVS + TVB + TV + TVF) * L * 2;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [11:0] solid_rgb = 12'h000;
    logic        frame_done;
    cam_state_t  state_dbg;
    int          cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cam_px_gen_if cam();

    cam_px_gen #(
        .H_ACT    (TH),
        .V_ACT    (TV),
        .H_BLANK  (TB),
        .VS_LINES (TVS),
        .VB_LINES (TVB),
        .VF_LINES (TVF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .mode       (mode),
        .solid_rgb  (solid_rgb),
        .cam        (cam),
        .frame_done (frame_done),
        .state_dbg  (state_dbg)
    );

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];
    logic [7:0] cap_q[$];
    int         done_q[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         vs_ticks, vs_to_href, href_pulses, href_bad, blank_nz;

    always @(negedge clk) if (frame_done) done_q.push_back(cyc);

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] model_rgb(input int m, input logic [11:0] s, input int x, input int y);
        logic [11:0] bars [8];
        logic [3:0]  xs, ys, ss;
        bars = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
        xs = 4'(x);
        ys = 4'(y);
        ss = 4'(x + y);
        if (m == 0) return bars[x / (TH / 8)];
        if (m == 1) return {xs, ys, ss};
        return s;
    endfunction

    task automatic push_frame(input int m, input logic [11:0] s);
        logic [11:0] c;
        exp_q.delete();
        for (int yy = 0; yy < TV; yy++) begin
            for (int xx = 0; xx < TH; xx++) begin
                c = model_rgb(m, s, xx, yy);
                exp_q.push_back({4'h0, c[11:8]});
                exp_q.push_back(c[7:0]);
            end
        end
    endtask

    // ---------------- driver / monitor tasks ----------------
    // Samples the bus once per pclk rising edge (negedge clk with pclk = 1)
    // from the first vsync-high tick until frame_done.
    task automatic capture_frame(input int budget);
        int  n = 0;
        int  tick_idx = 0;
        int  run = 0;
        bit  seen_vs = 0;
        bit  seen_href = 0;
        bit  done = 0;
        vs_ticks = 0; vs_to_href = -1; href_pulses = 0; href_bad = 0; blank_nz = 0;
        cap_q.delete();
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
            if (cam.CAM_pclk) begin
                if (cam.CAM_vsync) begin
                    seen_vs = 1;
                    vs_ticks++;
                end
                if (seen_vs) begin
                    if (cam.CAM_href) begin
                        if (!seen_href) vs_to_href = tick_idx;
                        seen_href = 1;
                        run++;
                        cap_q.push_back(cam.CAM_px_data);
                        if (exp_q.size() == 0) check_val("sb_underrun", 32'(cap_q.size()), 32'(2 * TH * TV));
                        else check_val("px_byte", 32'(cam.CAM_px_data), 32'(exp_q.pop_front()));
                    end else begin
                        if (run != 0) begin
                            href_pulses++;
                            if (run != 2 * TH) href_bad++;
                            run = 0;
                        end
                        if (cam.CAM_px_data != 8'h00) blank_nz++;
                    end
                    tick_idx++;
                end
            end
            if (frame_done && seen_vs) done = 1;
        end
        check_val("frame_done_seen", 32'(done), 32'd1);
        check_val("vsync_ticks", 32'(vs_ticks), 32'(TVS * L));
        check_val("vsync_to_href", 32'(vs_to_href), 32'((TVS + TVB) * L));
        check_val("href_pulses", 32'(href_pulses), 32'(TV));
        check_val("href_len_bad", 32'(href_bad), 32'd0);
        check_val("blank_data_nz", 32'(blank_nz), 32'd0);
        check_val("sb_leftover", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic set_at(input int delay, input int what, input logic [11:0] val);
        repeat (delay) @(negedge clk);
        case (what)
            0: mode = val[1:0];
            1: solid_rgb = val;
            default: enable = val[0];
        endcase
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int toggles, bad_idle, vs_high, n;
        logic prev;

        // 1. reset and idle
        repeat (3) @(negedge clk);
        check_val("rst_pclk", 32'(cam.CAM_pclk), 32'd0);
        check_val("rst_href", 32'(cam.CAM_href), 32'd0);
        check_val("rst_vsync", 32'(cam.CAM_vsync), 32'd0);
        check_val("rst_data", 32'(cam.CAM_px_data), 32'd0);
        check_val("rst_done", 32'(frame_done), 32'd0);
        check_val("rst_state", 32'(state_dbg), 32'(ST_IDLE));
        rst_n = 1'b1;
        toggles = 0; bad_idle = 0;
        prev = cam.CAM_pclk;
        repeat (200) begin
            @(negedge clk);
            if (cam.CAM_pclk != prev) toggles++;
            prev = cam.CAM_pclk;
            if (cam.CAM_href || cam.CAM_vsync || frame_done) bad_idle++;
        end
        check_val("idle_pclk_toggles", 32'(toggles), 32'd200);
        check_val("idle_outputs", 32'(bad_idle), 32'd0);
        check_val("idle_state", 32'(state_dbg), 32'(ST_IDLE));

        // 2. colour bars; mode -> gradient mid-frame takes effect next frame
        mode = 2'd0;
        enable = 1'b1;
        push_frame(0, 12'h000);
        fork
            capture_frame(3000);
            set_at(1000, 0, 12'h001);
        join
        check_val("bars_first_lo", 32'(cap_q.size() > 1 ? cap_q[0] : 8'hxx), 32'h0F);
        check_val("bars_first_hi", 32'(cap_q.size() > 1 ? cap_q[1] : 8'hxx), 32'hFF);
        check_val("bars_bar1_hi", 32'(cap_q.size() > 9 ? cap_q[9] : 8'hxx), 32'hF0);

        // 3. gradient; switch to solid A5C mid-frame
        push_frame(1, 12'h000);
        fork
            capture_frame(3000);
            begin
                set_at(1000, 0, 12'h002);
                set_at(0, 1, 12'hA5C);
            end
        join
        check_val("grad_y5_x17_lo", 32'(cap_q.size() > 5 * 64 + 35 ? cap_q[5 * 64 + 34] : 8'hxx), 32'h01);
        check_val("grad_y5_x17_hi", 32'(cap_q.size() > 5 * 64 + 35 ? cap_q[5 * 64 + 35] : 8'hxx), 32'h56);

        // 4. solid A5C; solid_rgb change mid-frame waits for next frame
        push_frame(2, 12'hA5C);
        fork
            capture_frame(3000);
            set_at(1000, 1, 12'h123);
        join
        check_val("solid_lo", 32'(cap_q.size() > 1 ? cap_q[0] : 8'hxx), 32'h0A);
        check_val("solid_hi_last", 32'(cap_q.size() > 0 ? cap_q[cap_q.size() - 1] : 8'hxx), 32'h5C);

        // 5. solid 123, enable dropped at line 4 of 8
        push_frame(2, 12'h123);
        fork
            capture_frame(3000);
            set_at(1250, 2, 12'h000);
        join
        vs_high = 0;
        repeat (2 * FRAME_CLK) begin
            @(negedge clk);
            if (cam.CAM_vsync) vs_high++;
        end
        check_val("stop_vsync_low", 32'(vs_high), 32'd0);
        check_val("stop_state", 32'(state_dbg), 32'(ST_IDLE));
        check_val("done_count", 32'(done_q.size()), 32'd4);
        if (done_q.size() >= 4) begin
            check_val("done_period_1", 32'(done_q[1] - done_q[0]), 32'(FRAME_CLK));
            check_val("done_period_2", 32'(done_q[2] - done_q[1]), 32'(FRAME_CLK));
            check_val("done_period_3", 32'(done_q[3] - done_q[2]), 32'(FRAME_CLK));
        end

        // 6. async reset mid-line at x = 16 of a bars frame
        mode = 2'd0;
        enable = 1'b1;
        n = 0;
        while (!cam.CAM_href && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check_val("restart_href_seen", 32'(cam.CAM_href), 32'd1);
        n = 0;
        while (n < 32) begin
            @(negedge clk);
            if (cam.CAM_pclk) n++;
        end
        #1 rst_n = 1'b0;
        #1;
        check_val("arst_pclk", 32'(cam.CAM_pclk), 32'd0);
        check_val("arst_href", 32'(cam.CAM_href), 32'd0);
        check_val("arst_vsync", 32'(cam.CAM_vsync), 32'd0);
        check_val("arst_data", 32'(cam.CAM_px_data), 32'd0);
        check_val("arst_state", 32'(state_dbg), 32'(ST_IDLE));
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_val("arst_release_state", 32'(state_dbg), 32'(ST_IDLE));
        push_frame(0, 12'h000);
        capture_frame(3000);
        check_val("arst_bar0_lo", 32'(cap_q.size() > 1 ? cap_q[0] : 8'hxx), 32'h0F);
        check_val("arst_bar0_hi", 32'(cap_q.size() > 1 ? cap_q[1] : 8'hxx), 32'hFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
